// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input vectors of a combinational block, captures its truth table and compares it to an expected one.
// Optional MISMATCH_LOG_EN adds first_err_idx/first_err_vld reporting the first mismatching row.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  localparam int TW = 1 << N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [TW-1:0]   expected,
  output logic [N_IN-1:0] f_in,
  input  logic            f_out,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   table_out,
  output logic            match,
  output logic [N_IN:0]   mismatch_cnt
`ifdef MISMATCH_LOG_EN
  ,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_vld
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [TW-1:0] exp_reg;
  logic diff, last;
  assign diff = f_out != exp_reg[f_in];
  assign last = &f_in;
  always_comb begin
    state_nxt = state == IDLE   ? (start ? WAIT : IDLE) :
                state == WAIT   ? (cnt == 4'(SETTLE - 1) ? SAMPLE : WAIT) :
                state == SAMPLE ? (last ? DONE : WAIT) : IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      f_in <= '0;
      cnt <= '0;
      exp_reg <= '0;
      table_out <= '0;
      mismatch_cnt <= '0;
      match <= 1'b0;
      busy <= 1'b0;
`ifdef MISMATCH_LOG_EN
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      f_in <= '0;
      cnt <= '0;
      exp_reg <= expected;
      table_out <= '0;
      mismatch_cnt <= '0;
      match <= 1'b0;
      busy <= 1'b1;
`ifdef MISMATCH_LOG_EN
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
`endif
    end else if (state == WAIT) begin
      cnt <= cnt + 4'd1;
    end else if (state == SAMPLE) begin
      table_out[f_in] <= f_out;
      if (diff) mismatch_cnt <= mismatch_cnt + 1'b1;
`ifdef MISMATCH_LOG_EN
      if (diff && !first_err_vld) begin
        first_err_idx <= f_in;
        first_err_vld <= 1'b1;
      end
`endif
      // match is settled on the last row so it is already valid while done pulses
      if (last) match <= mismatch_cnt == '0 && !diff;
      else begin
        f_in <= f_in + 1'b1;
        cnt <= '0;
      end
    end else if (state == DONE) begin
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized scoreboard bench; a truth-table model predicts each sweep's result and latency.
module tb_truth_table_sweeper;
  localparam int N_IN = 4, SETTLE = 2, TW = 16, SWEEP = TW * (SETTLE + 1);
  logic clk = 0, reset = 1, start = 0, f_out, busy, done, match;
  logic [TW-1:0] expected = '0, fn = '0, table_out;
  logic [N_IN-1:0] f_in;
  logic [N_IN:0] mismatch_cnt;
`ifdef MISMATCH_LOG_EN
  logic [N_IN-1:0] first_err_idx;
  logic first_err_vld;
`endif
  typedef struct {
    logic [TW-1:0] tbl;
    int mm;
    logic m;
    int first;
    int acc;
  } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0, cyc = 0;
  logic prev_done = 0;

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .f_in(f_in),
    .f_out(f_out), .busy(busy), .done(done), .table_out(table_out), .match(match),
    .mismatch_cnt(mismatch_cnt)
`ifdef MISMATCH_LOG_EN
    , .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
`endif
  );

  assign f_out = fn[f_in];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  function automatic exp_t model(logic [TW-1:0] f, logic [TW-1:0] ex, int acc);
    exp_t e;
    logic [TW-1:0] d = f ^ ex;
    e.tbl = f;
    e.mm = $countones(d);
    e.m = d == '0;
    e.first = -1;
    for (int i = TW - 1; i >= 0; i--) if (d[i]) e.first = i;
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (prev_done) chk("done_width", done, 0);
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc - e.acc, SWEEP);
        chk("table_out", table_out, e.tbl);
        chk("mismatch_cnt", mismatch_cnt, e.mm);
        chk("match", match, e.m);
`ifdef MISMATCH_LOG_EN
        chk("first_err_vld", first_err_vld, e.first >= 0);
        if (e.first >= 0) chk("first_err_idx", first_err_idx, e.first);
`endif
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 4 * SWEEP) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * SWEEP) begin
      checks++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic wait_fin(logic [N_IN-1:0] v);
    int n = 0;
    while (f_in !== v && n < 2 * SWEEP) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * SWEEP) begin
      checks++;
      $display("FAIL wait_fin: f_in %0h never reached %0h", f_in, v);
    end
  endtask

  task automatic run_sweep(logic [TW-1:0] f, logic [TW-1:0] ex);
    wait_idle();
    fn = f;
    expected = ex;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    q.push_back(model(f, ex, cyc));
    chk("busy_on_accept", busy, 1);
    expected = TW'($urandom);
  endtask

  initial begin
    logic [TW-1:0] r, e;
    int a;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_f_in", f_in, 0);
    chk("rst_table", table_out, 0);
    chk("rst_mm", mismatch_cnt, 0);
    chk("rst_match", match, 0);
    run_sweep(16'h8000, 16'h8000);
    run_sweep(16'hAAAA, 16'hAAAB);
    run_sweep(16'h00FF, 16'h0000);
    run_sweep(16'h00FF, 16'hFF00);
    // start re-pulsed mid sweep must not disturb it
    run_sweep(16'h8000, 16'h8001);
    wait_fin(5);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    // reset mid sweep discards the partial table
    run_sweep(16'h1234, 16'h1234);
    wait_fin(7);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    q.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_f_in", f_in, 0);
    chk("midrst_table", table_out, 0);
    chk("midrst_mm", mismatch_cnt, 0);
    run_sweep(16'h6996, 16'h6996);
    for (int k = 0; k < 6; k++) begin
      r = TW'($urandom);
      e = k % 3 == 0 ? r : k % 3 == 1 ? r ^ (TW'(1) << $urandom_range(TW - 1)) : TW'($urandom);
      run_sweep(r, e);
    end
    // start held high: back-to-back sweeps with one idle cycle between
    wait_idle();
    r = TW'($urandom);
    e = r ^ TW'($urandom_range(3));
    fn = r;
    expected = e;
    start = 1;
    @(posedge clk);
    #1;
    a = cyc;
    for (int k = 0; k < 3; k++) q.push_back(model(r, e, a + k * (SWEEP + 2)));
    repeat (2 * (SWEEP + 2)) @(posedge clk);
    #1 start = 0;
    wait_idle();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
